// File: rtl/seq_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : seq_multiplier
//  Description : Sequential unsigned shift-add multiplier. Computes
//                P = A * B (WIDTH x WIDTH -> 2*WIDTH) one multiplier bit per
//                clock behind a start/done handshake.
//  Ports       : clk   - rising-edge clock
//                rst   - asynchronous, active-high reset
//                start - request, sampled only in IDLE
//                A, B  - unsigned operands, captured on accepted start
//                busy  - high while a multiplication is running
//                done  - one-cycle pulse, P valid in the same cycle
//                P     - registered product, held until the next result
//  Options     : SEQ_MULT_ZERO_SKIP_EN - finish early once the remaining
//                multiplier bits (or the multiplicand) are zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] P
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0]       c_st_idle = 2'd0;
    localparam logic [1:0]       c_st_run  = 2'd1;
    localparam logic [1:0]       c_st_done = 2'd2;
    localparam logic [CNT_W-1:0] c_last    = CNT_W'(WIDTH - 1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] w_addend;
    logic               w_last_iter;
    logic               w_skip;

    // Partial product for the current bit position; the accumulator is wide
    // enough that the running sum can never overflow.
    assign w_addend    = {{WIDTH{1'b0}}, r_mcand} << r_cnt;
    assign w_last_iter = (r_cnt == c_last);

`ifdef SEQ_MULT_ZERO_SKIP_EN
    // Looks at the multiplier after this iteration's shift: once no set bits
    // remain, the accumulator already holds the final product.
    assign w_skip = (r_mcand == '0) || ((r_mplier >> 1) == '0);
`else
    assign w_skip = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (start) w_state_nxt = c_st_run;
            c_st_run:  if (w_last_iter || w_skip) w_state_nxt = c_st_done;
            c_st_done: w_state_nxt = c_st_idle;
            default:   w_state_nxt = c_st_idle;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and registered outputs. busy/done are decoded from the
    // current state and registered, so they trail the state by one cycle:
    // busy covers the WIDTH iteration cycles and done lands one edge after
    // the DONE state, alongside the freshly loaded P.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            P        <= '0;
        end else begin
            busy <= (r_state == c_st_run);
            done <= (r_state == c_st_done);
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_mcand  <= A;
                        r_mplier <= B;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                    end
                end
                c_st_run: begin
                    if (r_mplier[0]) begin
                        r_acc <= r_acc + w_addend;
                    end
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                end
                c_st_done: begin
                    P <= r_acc;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_multiplier.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_multiplier
//  Description : Self-checking bench for seq_multiplier (WIDTH = 4).
//                Expected products are queued when an operation is started
//                and compared when done pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_multiplier;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [2*WIDTH-1:0] P;

    logic [2*WIDTH-1:0] exp_q[$];
    int checks;
    int failures;

    seq_multiplier #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .P     (P)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clocks from the start edge to the edge after which done is high.
    function automatic int exp_lat(input int a, input int b);
`ifdef SEQ_MULT_ZERO_SKIP_EN
        if (a == 0 || b == 0) return 2;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (((b >> i) & 1) == 1) return 2 + i;
        end
        return 2;
`else
        if (a < 0 || b < 0) return 0;
        return WIDTH + 1;
`endif
    endfunction

    // Drives one start pulse, queues the expected product and waits
    // (bounded) for done. Called and returns at #1 after a rising edge.
    task automatic run_op(input int a, input int b, output int lat,
                          output int bcnt, output bit to);
        A     = WIDTH'(a);
        B     = WIDTH'(b);
        start = 1'b1;
        exp_q.push_back((2*WIDTH)'(a * b));
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; bcnt = 0; to = 1'b0;
        forever begin
            @(posedge clk); #1;
            lat++;
            if (busy) bcnt++;
            if (done) break;
            if (lat > 40) begin
                to = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; A = '0; B = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy actual=%b required=0", busy); end
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL reset_done actual=%b required=0", done); end
        checks++;
        if (P !== '0) begin failures++; $display("FAIL reset_P actual=%0d required=0", P); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_max;
        int lat, bcnt; bit to;
        logic [2*WIDTH-1:0] e;
        run_op(15, 15, lat, bcnt, to);
        e = exp_q.pop_front();
        checks++;
        if (to || P !== e) begin failures++; $display("FAIL max_P actual=%0d required=%0d timeout=%0d", P, e, to); end
        checks++;
        if (lat != exp_lat(15, 15)) begin failures++; $display("FAIL max_latency actual=%0d required=%0d", lat, exp_lat(15, 15)); end
        checks++;
        if (bcnt != WIDTH) begin failures++; $display("FAIL max_busy_cycles actual=%0d required=%0d", bcnt, WIDTH); end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL max_done_pulse actual=%b required=0", done); end
        checks++;
        if (P !== 8'hE1) begin failures++; $display("FAIL max_P_hold actual=%0d required=225", P); end
    endtask

    task automatic test_patterns;
        int av[3] = '{0, 1, 10};
        int bv[3] = '{9, 15, 12};
        int lat, bcnt; bit to;
        logic [2*WIDTH-1:0] e;
        for (int i = 0; i < 3; i++) begin
            run_op(av[i], bv[i], lat, bcnt, to);
            e = exp_q.pop_front();
            checks++;
            if (to || P !== e) begin failures++; $display("FAIL pattern_P a=%0d b=%0d actual=%0d required=%0d", av[i], bv[i], P, e); end
            checks++;
            if (lat != exp_lat(av[i], bv[i])) begin failures++; $display("FAIL pattern_latency a=%0d b=%0d actual=%0d required=%0d", av[i], bv[i], lat, exp_lat(av[i], bv[i])); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_start_while_busy;
        int bcnt, dcnt;
        logic [2*WIDTH-1:0] e;
        bcnt = 0; dcnt = 0;
        A = 4'd15; B = 4'd15; start = 1'b1;
        exp_q.push_back(8'd225);
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            @(posedge clk); #1;
            if (busy) bcnt++;
            if (done) begin
                dcnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL busy_start_extra_done actual=%0d required=none", P);
                end else begin
                    e = exp_q.pop_front();
                    if (P !== e) begin failures++; $display("FAIL busy_start_P actual=%0d required=%0d", P, e); end
                end
            end
            if (cyc == 1) begin A = 4'd3; B = 4'd3; start = 1'b1; end
            if (cyc == 2) start = 1'b0;
        end
        checks++;
        if (dcnt != 1) begin failures++; $display("FAIL busy_start_done_count actual=%0d required=1", dcnt); end
        checks++;
        if (bcnt != WIDTH) begin failures++; $display("FAIL busy_start_busy_cycles actual=%0d required=%0d", bcnt, WIDTH); end
    endtask

    task automatic test_async_reset;
        int dcnt, lat, bcnt; bit to;
        logic [2*WIDTH-1:0] e;
        A = 4'd15; B = 4'd15; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL async_rst_busy actual=%b required=0", busy); end
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL async_rst_done actual=%b required=0", done); end
        checks++;
        if (P !== '0) begin failures++; $display("FAIL async_rst_P actual=%0d required=0", P); end
        @(posedge clk); #1;
        rst = 1'b0;
        dcnt = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (done || busy) dcnt++;
        end
        checks++;
        if (dcnt != 0) begin failures++; $display("FAIL async_rst_activity actual=%0d required=0", dcnt); end
        run_op(7, 6, lat, bcnt, to);
        e = exp_q.pop_front();
        checks++;
        if (to || P !== e) begin failures++; $display("FAIL after_rst_P actual=%0d required=%0d", P, e); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        int pair, ndone, cyc;
        logic [2*WIDTH-1:0] last_p, e;
        pair = 0; ndone = 0; cyc = 0;
        A = WIDTH'(pair >> WIDTH); B = WIDTH'(pair & 15);
        exp_q.push_back((2*WIDTH)'((pair >> WIDTH) * (pair & 15)));
        pair++;
        start = 1'b1;
        last_p = P;
        @(posedge clk); #1;
        A = WIDTH'(pair >> WIDTH); B = WIDTH'(pair & 15);
        exp_q.push_back((2*WIDTH)'((pair >> WIDTH) * (pair & 15)));
        pair++;
        while (ndone < 256) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc > 3000) begin
                checks++; failures++;
                $display("FAIL sweep_timeout actual=%0d required=256 done pulses", ndone);
                break;
            end
            if (done) begin
                checks++;
                e = exp_q.pop_front();
                if (P !== e) begin failures++; $display("FAIL sweep_P op=%0d actual=%0d required=%0d", ndone, P, e); end
                ndone++;
                last_p = P;
                if (ndone < 256) begin
                    @(posedge clk); #1;
                    cyc++;
                    checks++;
                    if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL sweep_idle_gap busy=%b done=%b required=0/0", busy, done); end
                    if (pair < 256) begin
                        A = WIDTH'(pair >> WIDTH); B = WIDTH'(pair & 15);
                        exp_q.push_back((2*WIDTH)'((pair >> WIDTH) * (pair & 15)));
                        pair++;
                    end else begin
                        start = 1'b0;
                    end
                end
            end else begin
                checks++;
                if (P !== last_p) begin failures++; $display("FAIL sweep_P_stable actual=%0d required=%0d", P, last_p); end
            end
        end
        start = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL sweep_queue_left actual=%0d required=0", exp_q.size()); end
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1; start = 1'b0; A = '0; B = '0;
        test_reset();
        test_max();
        test_patterns();
        test_start_while_busy();
        test_async_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Sequential unsigned shift-add multiplier. Computes P = A × B for WIDTH-bit operands into a 2×WIDTH-bit product.
- Default 4×4 → 8-bit. Maximum case 15 × 15 = 225 must be exact.
- Sits as a small arithmetic datapath block behind a start/done handshake. Iterates one multiplier bit per clock to keep area minimal.

Parameters:
- WIDTH, 4, operand width in bits; product width is 2*WIDTH; legal range 2..16.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- A  input  WIDTH  multiplicand, unsigned; captured on accepted start.
- B  input  WIDTH  multiplier, unsigned; captured on accepted start.
- busy  output  1  high while a multiplication is in progress (RUN state).
- done  output  1  one-cycle pulse; P valid and updated in the same cycle.
- P  output  2*WIDTH  product register, unsigned.

Behaviour:
- One clock; reset is asynchronous and active-high (clk, rst). All state elements clear immediately on rst=1, independent of clk.
- Reset values: state=IDLE, busy=0, done=0, P=0, internal accumulator and counter = 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - On a rising edge with start=1, latch A into the multiplicand register and B into the multiplier shift register.
  - Clear the accumulator, set the counter to 0, and go to RUN.
  - With start=0, remain in IDLE.
- RUN, one iteration per clock:
  - If the multiplier LSB is 1, add (multiplicand << counter) into the 2*WIDTH-bit accumulator. No overflow is possible.
  - Shift the multiplier right by 1 and increment the counter.
  - After exactly WIDTH iterations, go to DONE.
- DONE, exactly one cycle:
  - P ← accumulator, registered at entry so it is visible while done=1.
  - done=1, then return to IDLE.
- Latency: start sampled at edge 0 → done=1 and P valid during the cycle following edge WIDTH+1. Default: 5 clocks from start edge to done cycle.
- busy=1 exactly in RUN. done=1 only in DONE. Both are registered outputs, decoded from state.
- start while busy or done is ignored: no queueing and no restart.
- start held high continuously: a new operation begins on the first edge in IDLE, i.e. back-to-back operations with one idle cycle between done and the next busy.
- A/B changes after capture have no effect on the running operation.
- P holds the last result until the next DONE. It is not cleared by start; only rst clears it.
- Reset mid-operation: rst aborts immediately, returns all outputs to reset values, and no done pulse is produced.
- Arithmetic is unsigned. The result equals the exact integer product for all 2^(2*WIDTH) operand pairs.

Optional Feature:
- Macro: SEQ_MULT_ZERO_SKIP_EN.
- Defined:
  - In RUN, if the remaining multiplier register is zero, go to DONE on the next edge instead of iterating further.
  - An operand A=0 or B=0 at capture yields done 2 clocks after the start edge.
  - General rule: latency = 2 + index of the highest set bit of B (or 2 if B=0 or A=0), capped at WIDTH+1.
  - P value is identical to the non-skip result.
- Undefined: fixed latency WIDTH+1 for all operands, as specified above.

Test Plan:
- rst=1 then release; start=1 with A=15, B=15 → done pulses 5 clocks after start edge, P=225 (8'hE1), busy high for exactly 4 cycles.
- A=0, B=9 → P=0 (fixed latency 5; 2 with SEQ_MULT_ZERO_SKIP_EN). Then A=1, B=15 → P=15. Then A=10, B=12 → P=120.
- Start pulse while busy with A=3, B=3 during a 15×15 run → P=225, no second done, busy not extended.
- rst asserted asynchronously mid-RUN (between clock edges) → busy, done and P drop to 0 immediately; no done afterward; the next start computes 7×6=42 correctly.
- Exhaustive sweep of all 256 A/B pairs with start held high → each done shows P=A*B; P stable between done pulses; one idle cycle between operations.
